// File: rtl/hazard_scoreboard.sv
// In-flight instruction scoreboard beside fetch/decode: detects register RAW and
// data-memory conflicts against DEPTH tracked stages and generates control-shadow bubbles.

module hazard_entry_cmp #(
    parameter int REG_W  = 3,
    parameter int ADDR_W = 16
) (
    input  logic              e_vld,
    input  logic [REG_W-1:0]  e_rd,
    input  logic              e_rd_wr,
    input  logic              e_mem_en,
    input  logic              e_mem_wr,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [REG_W-1:0]  rs_idx,
    input  logic              rs_used,
    input  logic [REG_W-1:0]  rt_idx,
    input  logic              rt_used,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              hit_rs,
    output logic              hit_rt,
    output logic              hit_mem
);
    logic wr_vld;

    assign wr_vld  = e_vld & e_rd_wr;
    assign hit_rs  = wr_vld & rs_used & (e_rd == rs_idx);
    assign hit_rt  = wr_vld & rt_used & (e_rd == rt_idx);
    // Load-load pairs never conflict: at least one side must be a store.
    assign hit_mem = e_vld & e_mem_en & (e_mem_wr | mem_wr) & (e_addr == mem_addr);
endmodule

module hazard_scoreboard #(
    parameter int NUM_REGS  = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 16,
    parameter bit FWD_EN    = 1'b0,
    parameter int BR_SHADOW = 1,
    localparam int REG_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_vld,
    input  logic [REG_W-1:0]  rs_idx,
    input  logic              rs_used,
    input  logic [REG_W-1:0]  rt_idx,
    input  logic              rt_used,
    input  logic [REG_W-1:0]  rd_idx,
    input  logic              rd_wr,
    input  logic              mem_en,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              is_ctl,
    input  logic              flush,
    output logic              pc_stall,
    output logic              bubble,
    output logic              haz_reg,
    output logic              haz_mem,
    output logic [2:0]        shadow_cnt
);
    localparam logic [2:0] SHADOW_LEN = 3'(BR_SHADOW);

    typedef struct packed {
        logic              vld;
        logic [REG_W-1:0]  rd;
        logic              rd_wr;
        logic              is_ld;
        logic              mem_en;
        logic              mem_wr;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    entry_t             ent [DEPTH];
    entry_t             new_ent;
    logic [DEPTH-1:0]   hit_rs, hit_rt, hit_mem;
    logic               shadow, accept;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        hazard_entry_cmp #(.REG_W(REG_W), .ADDR_W(ADDR_W)) u_cmp (
            .e_vld    (ent[g].vld),
            .e_rd     (ent[g].rd),
            .e_rd_wr  (ent[g].rd_wr),
            .e_mem_en (ent[g].mem_en),
            .e_mem_wr (ent[g].mem_wr),
            .e_addr   (ent[g].addr),
            .rs_idx   (rs_idx),
            .rs_used  (rs_used),
            .rt_idx   (rt_idx),
            .rt_used  (rt_used),
            .mem_wr   (mem_wr),
            .mem_addr (mem_addr),
            .hit_rs   (hit_rs[g]),
            .hit_rt   (hit_rt[g]),
            .hit_mem  (hit_mem[g])
        );
    end

    always_comb begin
        // With forwarding only a load in the youngest slot cannot be bypassed.
        if (FWD_EN)
            haz_reg = issue_vld & (hit_rs[0] | hit_rt[0]) & ent[0].is_ld;
        else
            haz_reg = issue_vld & (|(hit_rs | hit_rt));
        haz_mem  = issue_vld & mem_en & (|hit_mem);
        shadow   = (shadow_cnt != 3'd0);
        pc_stall = ~flush & (haz_reg | haz_mem);
        bubble   = ~flush & (haz_reg | haz_mem | shadow);
        accept   = issue_vld & ~flush & ~pc_stall & ~shadow;
    end

    always_comb begin
        new_ent        = '0;
        new_ent.vld    = 1'b1;
        new_ent.rd     = rd_idx;
        new_ent.rd_wr  = rd_wr;
        new_ent.is_ld  = mem_en & ~mem_wr & rd_wr;
        new_ent.mem_en = mem_en;
        new_ent.mem_wr = mem_wr;
        new_ent.addr   = mem_addr;
    end

    // The tracker never stalls: a held instruction lets older stages drain past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            ent[0] <= accept ? new_ent : '0;
            for (int i = 1; i < DEPTH; i++) ent[i] <= ent[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                shadow_cnt <= 3'd0;
        else if (flush)            shadow_cnt <= 3'd0;
        else if (accept && is_ctl) shadow_cnt <= SHADOW_LEN;
        else if (shadow)           shadow_cnt <= shadow_cnt - 3'd1;
    end
endmodule
